// File: rtl/img_rsz_pkg.sv
// img_rsz_pkg: shared types and default widths for the image resizer.
// Center-aligned mapping is selected with IMG_RSZ_CENTER_ALIGN_EN.
package img_rsz_pkg;

   localparam int IMG_RSZ_DIM_W  = 12;
   localparam int IMG_RSZ_FRAC_W = 4;

   typedef enum logic [1:0] {
      CG_IDLE,
      CG_REQ_Y,
      CG_REQ_X,
      CG_DONE
   } img_rsz_cg_state_t;

   typedef struct packed {
      logic is_y;
      logic eol;
      logic eof;
   } img_rsz_tag_t;

endpackage

// File: rtl/img_rsz_axis_acc.sv
// img_rsz_axis_acc: per-axis numerator accumulator and denominator.
// IMG_RSZ_CENTER_ALIGN_EN selects pixel-center instead of corner mapping.
module img_rsz_axis_acc
   import img_rsz_pkg::*;
#(
   parameter int DIM_W = IMG_RSZ_DIM_W,
   parameter int FRAC_W = IMG_RSZ_FRAC_W,
   parameter int NUM_W = 40,
   parameter int DEN_W = 32
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Load,
   input  logic             Inc,
   input  logic [DIM_W-1:0] S,
   input  logic [DIM_W-1:0] D,
   output logic [NUM_W-1:0] Acc,
   output logic [DEN_W-1:0] Den
);

   logic [NUM_W-1:0] s_ext;
   logic [NUM_W-1:0] init_val;
   logic [NUM_W-1:0] step_val;

   assign s_ext = NUM_W'(S);

`ifdef IMG_RSZ_CENTER_ALIGN_EN
   assign init_val = s_ext << FRAC_W;
   assign step_val = s_ext << (FRAC_W + 1);
   assign Den      = DEN_W'(D) << 1;
`else
   assign init_val = '0;
   assign step_val = s_ext << FRAC_W;
   assign Den      = DEN_W'(D);
`endif

   always_ff @(posedge Clk) begin
      if (Rst) begin
         Acc <= '0;
      end else if (Load) begin
         Acc <= init_val;
      end else if (Inc) begin
         Acc <= Acc + step_val;
      end
   end

endmodule

// File: rtl/img_rsz_coord_gen.sv
// img_rsz_coord_gen: walks the destination raster and issues Y/X
// numerator/denominator requests to the divider (IMG_RSZ_CENTER_ALIGN_EN).
module img_rsz_coord_gen
   import img_rsz_pkg::*;
#(
   parameter int DIM_W = IMG_RSZ_DIM_W,
   parameter int FRAC_W = IMG_RSZ_FRAC_W,
   parameter int NUMINATOR_W = 40,
   parameter int DENOMINATOR_W = 32
) (
   input  logic                     Clk,
   input  logic                     Rst,
   input  logic [DIM_W-1:0]         CfgSrcW,
   input  logic [DIM_W-1:0]         CfgSrcH,
   input  logic [DIM_W-1:0]         CfgDstW,
   input  logic [DIM_W-1:0]         CfgDstH,
   input  logic                     Start,
   output logic                     Busy,
   output logic                     CfgErr,
   output logic                     FrameDone,
   output logic [NUMINATOR_W-1:0]   Numinator,
   output logic [DENOMINATOR_W-1:0] Denominator,
   output logic                     TagIsY,
   output logic                     TagEol,
   output logic                     TagEof,
   output logic                     FwVld,
   input  logic                     FwRdy
);

   img_rsz_cg_state_t state_q, state_d;
   img_rsz_tag_t      tag;

   logic [DIM_W-1:0] src_w_q, src_h_q, dst_w_q, dst_h_q;
   logic [DIM_W-1:0] row_q, col_q;
   logic [DIM_W-1:0] s_y;
   logic             cfg_err_q;
   logic             cfg_zero, start_ok, cfg_bad;
   logic             is_y, is_x, hs, y_hs, x_hs;
   logic             last_col, last_row;

   logic [NUMINATOR_W-1:0]   acc_x, acc_y;
   logic [DENOMINATOR_W-1:0] den_x, den_y;

   assign is_y     = (state_q == CG_REQ_Y);
   assign is_x     = (state_q == CG_REQ_X);
   assign hs       = FwVld & FwRdy;
   assign y_hs     = is_y & hs;
   assign x_hs     = is_x & hs;
   assign last_col = (col_q == dst_w_q - DIM_W'(1));
   assign last_row = (row_q == dst_h_q - DIM_W'(1));
   assign cfg_zero = (CfgSrcW == '0) | (CfgSrcH == '0)
                   | (CfgDstW == '0) | (CfgDstH == '0);

   // Y step must come from the latched height once the frame runs.
   assign s_y = (state_q == CG_IDLE) ? CfgSrcH : src_h_q;

   img_rsz_axis_acc #(
      .DIM_W(DIM_W), .FRAC_W(FRAC_W),
      .NUM_W(NUMINATOR_W), .DEN_W(DENOMINATOR_W)
   ) u_acc_y (
      .Clk(Clk), .Rst(Rst),
      .Load(start_ok), .Inc(y_hs),
      .S(s_y), .D(dst_h_q),
      .Acc(acc_y), .Den(den_y)
   );

   img_rsz_axis_acc #(
      .DIM_W(DIM_W), .FRAC_W(FRAC_W),
      .NUM_W(NUMINATOR_W), .DEN_W(DENOMINATOR_W)
   ) u_acc_x (
      .Clk(Clk), .Rst(Rst),
      .Load(y_hs), .Inc(x_hs & ~last_col),
      .S(src_w_q), .D(dst_w_q),
      .Acc(acc_x), .Den(den_x)
   );

   always_comb begin
      state_d  = state_q;
      start_ok = 1'b0;
      cfg_bad  = 1'b0;
      unique case (state_q)
         CG_IDLE: begin
            if (Start && cfg_zero) begin
               cfg_bad = 1'b1;
            end else if (Start) begin
               start_ok = 1'b1;
               state_d  = CG_REQ_Y;
            end
         end
         CG_REQ_Y: if (hs) state_d = CG_REQ_X;
         CG_REQ_X: begin
            if (hs && last_col)
               state_d = last_row ? CG_DONE : CG_REQ_Y;
         end
         CG_DONE:  state_d = CG_IDLE;
         default:  state_d = CG_IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q   <= CG_IDLE;
         cfg_err_q <= 1'b0;
         src_w_q   <= '0;
         src_h_q   <= '0;
         dst_w_q   <= '0;
         dst_h_q   <= '0;
         row_q     <= '0;
         col_q     <= '0;
      end else begin
         state_q   <= state_d;
         cfg_err_q <= cfg_bad;
         if (start_ok) begin
            src_w_q <= CfgSrcW;
            src_h_q <= CfgSrcH;
            dst_w_q <= CfgDstW;
            dst_h_q <= CfgDstH;
            row_q   <= '0;
         end
         if (y_hs)
            col_q <= '0;
         else if (x_hs && !last_col)
            col_q <= col_q + DIM_W'(1);
         if (x_hs && last_col && !last_row)
            row_q <= row_q + DIM_W'(1);
      end
   end

   always_comb begin
      Numinator   = '0;
      Denominator = '0;
      unique case (1'b1)
         is_y: begin
            Numinator   = acc_y;
            Denominator = den_y;
         end
         is_x: begin
            Numinator   = acc_x;
            Denominator = den_x;
         end
         default: ;
      endcase
   end

   assign tag.is_y = is_y;
   assign tag.eol  = is_x & last_col;
   assign tag.eof  = is_x & last_col & last_row;

   assign TagIsY    = tag.is_y;
   assign TagEol    = tag.eol;
   assign TagEof    = tag.eof;
   assign FwVld     = is_y | is_x;
   assign Busy      = (state_q != CG_IDLE);
   assign FrameDone = (state_q == CG_DONE);
   assign CfgErr    = cfg_err_q;

endmodule

// File: tb/tb_img_rsz_coord_gen.sv
// tb_img_rsz_coord_gen: scoreboard bench for the resizer coordinate generator.
// Expected requests come from the mapping formula, built with IMG_RSZ_CENTER_ALIGN_EN or not.
module tb_img_rsz_coord_gen;

   localparam int DIM_W  = 12;
   localparam int FRAC_W = 4;
   localparam int NUM_W  = 40;
   localparam int DEN_W  = 32;

   logic             Clk = 1'b0;
   logic             Rst = 1'b1;
   logic             Start = 1'b0;
   logic             FwRdy = 1'b0;
   logic [DIM_W-1:0] CfgSrcW = '0, CfgSrcH = '0;
   logic [DIM_W-1:0] CfgDstW = '0, CfgDstH = '0;
   logic             Busy, CfgErr, FrameDone;
   logic [NUM_W-1:0] Numinator;
   logic [DEN_W-1:0] Denominator;
   logic             TagIsY, TagEol, TagEof, FwVld;

   img_rsz_coord_gen #(
      .DIM_W(DIM_W), .FRAC_W(FRAC_W),
      .NUMINATOR_W(NUM_W), .DENOMINATOR_W(DEN_W)
   ) dut (
      .Clk(Clk), .Rst(Rst),
      .CfgSrcW(CfgSrcW), .CfgSrcH(CfgSrcH),
      .CfgDstW(CfgDstW), .CfgDstH(CfgDstH),
      .Start(Start), .Busy(Busy), .CfgErr(CfgErr),
      .FrameDone(FrameDone),
      .Numinator(Numinator), .Denominator(Denominator),
      .TagIsY(TagIsY), .TagEol(TagEol), .TagEof(TagEof),
      .FwVld(FwVld), .FwRdy(FwRdy)
   );

   initial forever #5 Clk = ~Clk;

   typedef struct {
      logic [NUM_W-1:0] num;
      logic [DEN_W-1:0] den;
      logic             y;
      logic             eol;
      logic             eof;
   } req_t;

   req_t exp_q[$];
   req_t em;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int hs_cnt = 0;
   int done_cnt = 0;
   int rdy_mode = 0;
   int bp_left = 0;

   task automatic chk(input bit ok, input string name,
                      input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (ok) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Source coordinate (scaled by 2^FRAC_W) = numerator / denominator.
   function automatic logic [63:0] map_num(input int idx, input int s);
`ifdef IMG_RSZ_CENTER_ALIGN_EN
      return (64'(2 * idx + 1) * 64'(s)) << FRAC_W;
`else
      return (64'(idx) * 64'(s)) << FRAC_W;
`endif
   endfunction

   function automatic logic [63:0] map_den(input int d);
`ifdef IMG_RSZ_CENTER_ALIGN_EN
      return 64'(2 * d);
`else
      return 64'(d);
`endif
   endfunction

   task automatic push_frame(input int sw, input int sh,
                             input int dw, input int dh);
      req_t e;
      for (int r = 0; r < dh; r++) begin
         e.num = NUM_W'(map_num(r, sh));
         e.den = DEN_W'(map_den(dh));
         e.y = 1'b1; e.eol = 1'b0; e.eof = 1'b0;
         exp_q.push_back(e);
         for (int c = 0; c < dw; c++) begin
            e.num = NUM_W'(map_num(c, sw));
            e.den = DEN_W'(map_den(dw));
            e.y   = 1'b0;
            e.eol = (c == dw - 1);
            e.eof = (c == dw - 1) && (r == dh - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   // Ready driver: 0 always ready, 1 random, 2 stall third request 5 cycles.
   initial forever begin
      @(posedge Clk);
      #1;
      case (rdy_mode)
         0: FwRdy = 1'b1;
         1: FwRdy = 1'($urandom_range(0, 1));
         default: begin
            if (hs_cnt == 2 && bp_left > 0) begin
               FwRdy = 1'b0;
               bp_left--;
            end else begin
               FwRdy = 1'b1;
            end
         end
      endcase
   end

   // Monitor: samples mid-cycle, ahead of the edge that completes a handshake.
   logic        prev_eof = 1'b0;
   logic        hold_vld = 1'b0;
   logic [78:0] held;
   initial forever begin
      @(negedge Clk);
      if (Rst) begin
         prev_eof = 1'b0;
         hold_vld = 1'b0;
      end else begin
         if (FrameDone || prev_eof)
            chk(FrameDone == prev_eof, "frame_done_timing", FrameDone, prev_eof);
         if (FrameDone) done_cnt++;
         prev_eof = 1'b0;
         if (Busy)
            chk(!CfgErr, "cfg_err_while_busy", CfgErr, 0);
         if (hold_vld)
            chk({FwVld, Numinator, Denominator, TagIsY, TagEol, TagEof} == held,
                "stall_stable", Numinator, held[74:35]);
         hold_vld = FwVld && !FwRdy;
         held = {FwVld, Numinator, Denominator, TagIsY, TagEol, TagEof};
         if (FwVld && FwRdy) begin
            hs_cnt++;
            prev_eof = TagEof;
            if (exp_q.size() == 0) begin
               chk(1'b0, "unexpected_request", Numinator, 0);
            end else begin
               em = exp_q.pop_front();
               chk(Numinator == em.num, "req_num", Numinator, em.num);
               chk(Denominator == em.den, "req_den", Denominator, em.den);
               chk({TagIsY, TagEol, TagEof} == {em.y, em.eol, em.eof},
                   "req_tags", {TagIsY, TagEol, TagEof}, {em.y, em.eol, em.eof});
            end
         end
      end
   end

   task automatic check_all_zero(input string name);
      chk({FwVld, Busy, CfgErr, FrameDone, TagIsY, TagEol, TagEof} == 7'd0
          && Numinator == '0 && Denominator == '0, name,
          {FwVld, Busy, CfgErr, FrameDone, TagIsY, TagEol, TagEof}, 0);
   endtask

   task automatic run_frame(input int sw, input int sh,
                            input int dw, input int dh, input int mode);
      int old;
      old      = done_cnt;
      hs_cnt   = 0;
      bp_left  = 5;
      rdy_mode = mode;
      CfgSrcW  = DIM_W'(sw);
      CfgSrcH  = DIM_W'(sh);
      CfgDstW  = DIM_W'(dw);
      CfgDstH  = DIM_W'(dh);
      push_frame(sw, sh, dw, dh);
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      chk(Busy && FwVld, "start_accept", {Busy, FwVld}, 2'b11);
      // Random Start/config while busy, Done cycle included, must be ignored.
      for (int n = 0; n < 4000 && done_cnt == old; n++) begin
         @(posedge Clk);
         #1;
         Start   = 1'($urandom_range(0, 1));
         CfgSrcW = DIM_W'($urandom);
         CfgSrcH = DIM_W'($urandom);
         CfgDstW = DIM_W'($urandom_range(0, 3));
         CfgDstH = DIM_W'($urandom_range(0, 3));
      end
      Start = 1'b0;
      chk(done_cnt == old + 1, "frame_done_seen", done_cnt, old + 1);
      chk(!Busy, "idle_after_done", Busy, 0);
      chk(exp_q.size() == 0, "queue_drained", exp_q.size(), 0);
      chk(hs_cnt == dh * (dw + 1), "request_count", hs_cnt, dh * (dw + 1));
      exp_q.delete();
   endtask

   initial begin
      int old;
      repeat (3) @(posedge Clk);
      #1;
      check_all_zero("reset_values");
      Rst = 1'b0;
      @(posedge Clk);
      #1;
      check_all_zero("idle_after_reset");

      run_frame(4, 2, 8, 4, 0);
      run_frame(4, 2, 3, 2, 0);
      run_frame(4, 2, 4, 3, 2);

      CfgSrcW = 12'd4; CfgSrcH = 12'd2;
      CfgDstW = 12'd0; CfgDstH = 12'd2;
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      chk(CfgErr && !Busy && !FwVld, "cfg_err_pulse", {CfgErr, Busy, FwVld}, 3'b100);
      @(posedge Clk);
      #1;
      chk(!CfgErr && !Busy && !FwVld, "cfg_err_single", {CfgErr, Busy, FwVld}, 0);

      old      = done_cnt;
      hs_cnt   = 0;
      rdy_mode = 0;
      CfgSrcW = 12'd5; CfgSrcH = 12'd7;
      CfgDstW = 12'd4; CfgDstH = 12'd3;
      push_frame(5, 7, 4, 3);
      Start = 1'b1;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      for (int n = 0; n < 200 && hs_cnt < 3; n++) begin
         @(posedge Clk);
         #1;
      end
      chk(hs_cnt == 3, "reached_three_hs", hs_cnt, 3);
      Rst = 1'b1;
      exp_q.delete();
      @(posedge Clk);
      #1;
      Rst = 1'b0;
      check_all_zero("mid_frame_reset");
      repeat (6) @(posedge Clk);
      #1;
      chk(done_cnt == old, "no_done_after_abort", done_cnt, old);
      run_frame(5, 7, 4, 3, 1);

      run_frame(4095, 4095, 1, 1, 1);
      run_frame(1, 4095, 12, 2, 1);
      for (int i = 0; i < 12; i++)
         run_frame($urandom_range(1, 4095), $urandom_range(1, 4095),
                   $urandom_range(1, 12), $urandom_range(1, 6), 1);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
